// File: rtl/control_fsm_if.sv
// control_fsm_if: control-unit bus.
//   master (control_fsm): start and instr_data in; instr_addr, decoded
//   instruction fields, strobes and status out.
//   slave  (datapath / ROM / bench): the mirror image.
interface control_fsm_if #(
    parameter int PC_W  = 8,
    parameter int CNT_W = 8
);
    logic             start;
    logic [PC_W-1:0]  instr_addr;
    logic [7:0]       instr_data;
    logic [3:0]       opcode;
    logic [3:0]       operand;
    logic [2:0]       alu_ctrl;
    logic             reg_we;
    logic             mem_we;
    logic             halted;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    modport master (
        input  start, instr_data,
        output instr_addr, opcode, operand, alu_ctrl,
               reg_we, mem_we, halted, illegal, retired
    );

    modport slave (
        output start, instr_data,
        input  instr_addr, opcode, operand, alu_ctrl,
               reg_we, mem_we, halted, illegal, retired
    );
endinterface

// File: rtl/control_fsm.sv
// control_fsm: multicycle control unit (FETCH / DECODE / EXEC, 3 cycles per
// instruction) for the simple processor.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - control_fsm_if.master: start, ROM address/data, decoded opcode,
//          operand, alu_ctrl, reg_we/mem_we strobes, halted, illegal, retired
module control_fsm #(
    parameter int PC_W  = 8,
    parameter int CNT_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    control_fsm_if.master  bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        HALT   = 3'd4
    } state_t;

    localparam logic [3:0] OP_STORE = 4'h1;
    localparam logic [3:0] OP_JMP   = 4'h8;
    localparam logic [3:0] OP_NOP   = 4'hE;
    localparam logic [3:0] OP_HALT  = 4'hF;

    state_t           state, state_nxt;
    logic [PC_W-1:0]  pc, pc_nxt;
    logic [7:0]       ir;
    logic [2:0]       alu_q;
    logic [CNT_W-1:0] retired_q;
    logic             reg_we_c, mem_we_c, illegal_c;

    function automatic logic [2:0] alu_of(input logic [3:0] op);
        case (op)
            4'h3:    alu_of = 3'b001;
            4'h4:    alu_of = 3'b010;
            4'h5:    alu_of = 3'b011;
            4'h6:    alu_of = 3'b100;
            4'h7:    alu_of = 3'b101;
            default: alu_of = 3'b000;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= '0;
            ir        <= {OP_NOP, 4'h0};
            alu_q     <= 3'b000;
            retired_q <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (state == DECODE) begin
                ir    <= bus.instr_data;
                alu_q <= alu_of(bus.instr_data[7:4]);
            end
            if (state == EXEC)
                retired_q <= retired_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        reg_we_c  = 1'b0;
        mem_we_c  = 1'b0;
        illegal_c = 1'b0;
        case (state)
            IDLE:   if (bus.start) state_nxt = FETCH;
            FETCH:  state_nxt = DECODE;
            DECODE: begin
                pc_nxt    = pc + PC_W'(1);
                state_nxt = EXEC;
            end
            EXEC: begin
                state_nxt = FETCH;
                case (ir[7:4])
                    4'h0, 4'h2, 4'h3, 4'h4,
                    4'h5, 4'h6, 4'h7: reg_we_c = 1'b1;
                    OP_STORE:         mem_we_c = 1'b1;
                    OP_JMP:           pc_nxt   = PC_W'(ir[3:0]);
                    OP_NOP:           ;
                    OP_HALT:          state_nxt = HALT;
                    default:          illegal_c = 1'b1;
                endcase
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes are combinational from EXEC; gating with rst kills a write
    // that would otherwise fire in the same cycle reset is taken.
    assign bus.reg_we     = reg_we_c  & ~rst;
    assign bus.mem_we     = mem_we_c  & ~rst;
    assign bus.illegal    = illegal_c & ~rst;
    assign bus.halted     = (state == HALT);
    assign bus.instr_addr = pc;
    assign bus.opcode     = ir[7:4];
    assign bus.operand    = ir[3:0];
    assign bus.alu_ctrl   = alu_q;
    assign bus.retired    = retired_q;
endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: self-checking bench for control_fsm. An instruction-level
// model (program counter, retire count, opcode table) predicts what each
// FETCH/DECODE/EXEC cycle must show; a second instance with PC_W=4 covers
// program-counter wrap.
module tb_control_fsm;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    control_fsm_if #(.PC_W(8), .CNT_W(8)) bus1 ();
    control_fsm_if #(.PC_W(4), .CNT_W(8)) bus2 ();

    control_fsm #(.PC_W(8), .CNT_W(8)) dut  (.clk(clk), .rst(rst), .bus(bus1));
    control_fsm #(.PC_W(4), .CNT_W(8)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    logic [7:0] rom1 [256];
    logic [7:0] rom2 [16];

    always @(posedge clk) bus1.instr_data <= rom1[bus1.instr_addr];
    always @(posedge clk) bus2.instr_data <= rom2[bus2.instr_addr];

    int tests = 0;
    int fails = 0;

    // Opcode table: kind 0 = no strobe, 1 = reg_we, 2 = mem_we, 3 = illegal
    int         kind  [16];
    logic [2:0] alu_t [16];

    int   mpc;
    int   mret;

    task automatic init_tables();
        for (int i = 0; i < 16; i++) begin
            kind[i]  = 3;
            alu_t[i] = 3'b000;
        end
        kind[0] = 1; kind[1] = 2; kind[2] = 1; kind[3] = 1;
        kind[4] = 1; kind[5] = 1; kind[6] = 1; kind[7] = 1;
        kind[8] = 0; kind[14] = 0; kind[15] = 0;
        alu_t[3] = 3'b001; alu_t[4] = 3'b010; alu_t[5] = 3'b011;
        alu_t[6] = 3'b100; alu_t[7] = 3'b101;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus1.start = 1'b0;
        bus2.start = 1'b0;
        for (int i = 0; i < 256; i++) rom1[i] = 8'hE0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        mpc  = 0;
        mret = 0;
    endtask

    task automatic kick();
        bus1.start = 1'b1;
        step();
        bus1.start = 1'b0;
    endtask

    // Entered at the sampling point of a FETCH cycle. start is toggled at
    // random throughout, which must have no effect outside IDLE.
    task automatic exec_instrs(input string tag, input int n);
        logic [7:0] ins;
        int         op;
        bit         stop;
        stop = 0;
        for (int k = 0; k < n && !stop; k++) begin
            ins = rom1[mpc];
            op  = int'(ins[7:4]);
            tests++;
            if (bus1.instr_addr !== 8'(mpc)) begin
                fails++;
                $display("FAIL %s fetch_addr k=%0d got %0d exp %0d", tag, k, bus1.instr_addr, mpc);
            end
            step();
            bus1.start = 1'($urandom_range(0, 1));
            tests++;
            if ({bus1.reg_we, bus1.mem_we, bus1.illegal} !== 3'b000) begin
                fails++;
                $display("FAIL %s decode_strobes k=%0d got %b exp 000", tag, k,
                         {bus1.reg_we, bus1.mem_we, bus1.illegal});
            end
            step();
            bus1.start = 1'($urandom_range(0, 1));
            tests++;
            if (bus1.opcode !== ins[7:4] || bus1.operand !== ins[3:0] ||
                bus1.alu_ctrl !== alu_t[op] ||
                bus1.reg_we !== (kind[op] == 1) || bus1.mem_we !== (kind[op] == 2) ||
                bus1.illegal !== (kind[op] == 3)) begin
                fails++;
                $display("FAIL %s exec k=%0d got op=%h opd=%h alu=%b rw=%b mw=%b il=%b exp op=%h opd=%h alu=%b rw=%b mw=%b il=%b",
                         tag, k, bus1.opcode, bus1.operand, bus1.alu_ctrl, bus1.reg_we,
                         bus1.mem_we, bus1.illegal, ins[7:4], ins[3:0], alu_t[op],
                         kind[op] == 1, kind[op] == 2, kind[op] == 3);
            end
            mret = (mret + 1) % 256;
            mpc  = (op == 8) ? int'(ins[3:0]) : (mpc + 1) % 256;
            step();
            bus1.start = 1'($urandom_range(0, 1));
            tests++;
            if (bus1.retired !== 8'(mret) || bus1.halted !== (op == 15)) begin
                fails++;
                $display("FAIL %s retire k=%0d got ret=%0d halted=%b exp ret=%0d halted=%b",
                         tag, k, bus1.retired, bus1.halted, mret, op == 15);
            end
            if (op == 15) stop = 1;
        end
        bus1.start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (bus1.instr_addr !== 8'd0 || bus1.retired !== 8'd0 || bus1.opcode !== 4'hE ||
                bus1.operand !== 4'h0 || bus1.alu_ctrl !== 3'b000 || bus1.reg_we !== 1'b0 ||
                bus1.mem_we !== 1'b0 || bus1.halted !== 1'b0 || bus1.illegal !== 1'b0) begin
                fails++;
                $display("FAIL reset_idle cyc=%0d got addr=%0d ret=%0d op=%h opd=%h alu=%b rw=%b mw=%b h=%b il=%b exp 0 0 E 0 000 0 0 0 0",
                         i, bus1.instr_addr, bus1.retired, bus1.opcode, bus1.operand,
                         bus1.alu_ctrl, bus1.reg_we, bus1.mem_we, bus1.halted, bus1.illegal);
            end
            step();
        end
    endtask

    task automatic test_add();
        do_reset();
        rom1[0] = 8'h2B;
        kick();
        exec_instrs("add", 2);
    endtask

    task automatic test_halt();
        do_reset();
        rom1[0] = 8'h15; rom1[1] = 8'h34; rom1[2] = 8'hF0;
        kick();
        exec_instrs("halt_prog", 3);
        for (int i = 0; i < 22; i++) begin
            bus1.start = 1'($urandom_range(0, 1));
            tests++;
            if (bus1.halted !== 1'b1 || bus1.retired !== 8'd3 || bus1.instr_addr !== 8'd3 ||
                bus1.reg_we !== 1'b0 || bus1.mem_we !== 1'b0 || bus1.illegal !== 1'b0) begin
                fails++;
                $display("FAIL halt_hold cyc=%0d got h=%b ret=%0d addr=%0d rw=%b mw=%b il=%b exp 1 3 3 0 0 0",
                         i, bus1.halted, bus1.retired, bus1.instr_addr, bus1.reg_we,
                         bus1.mem_we, bus1.illegal);
            end
            step();
        end
        bus1.start = 1'b0;
    endtask

    task automatic test_jmp();
        do_reset();
        rom1[0] = 8'h86; rom1[6] = 8'h70;
        kick();
        exec_instrs("jmp", 3);
        do_reset();
        rom1[0] = 8'h80;
        kick();
        exec_instrs("jmp_self", 6);
    endtask

    task automatic test_illegal();
        do_reset();
        rom1[0] = 8'hA3;
        kick();
        exec_instrs("illegal", 2);
    endtask

    task automatic test_reset_in_exec();
        do_reset();
        rom1[0] = 8'h2B;
        kick();
        step();
        step();
        tests++;
        if (bus1.reg_we !== 1'b1) begin
            fails++;
            $display("FAIL rst_exec_pre reg_we got %b exp 1", bus1.reg_we);
        end
        rst = 1'b1;
        #1;
        tests++;
        if (bus1.reg_we !== 1'b0 || bus1.mem_we !== 1'b0) begin
            fails++;
            $display("FAIL rst_exec_strobe got rw=%b mw=%b exp 0 0", bus1.reg_we, bus1.mem_we);
        end
        step();
        rst = 1'b0;
        tests++;
        if (bus1.instr_addr !== 8'd0 || bus1.retired !== 8'd0 || bus1.opcode !== 4'hE ||
            bus1.halted !== 1'b0) begin
            fails++;
            $display("FAIL rst_exec_after got addr=%0d ret=%0d op=%h h=%b exp 0 0 E 0",
                     bus1.instr_addr, bus1.retired, bus1.opcode, bus1.halted);
        end
        step();
        step();
        tests++;
        if (bus1.instr_addr !== 8'd0 || bus1.retired !== 8'd0 || bus1.reg_we !== 1'b0) begin
            fails++;
            $display("FAIL rst_exec_idle got addr=%0d ret=%0d rw=%b exp 0 0 0",
                     bus1.instr_addr, bus1.retired, bus1.reg_we);
        end
    endtask

    task automatic test_random();
        for (int p = 0; p < 4; p++) begin
            do_reset();
            for (int i = 0; i < 256; i++) begin
                logic [7:0] b;
                b = 8'($urandom);
                while (b[7:4] == 4'hF) b = 8'($urandom);
                rom1[i] = b;
            end
            kick();
            exec_instrs($sformatf("rand%0d", p), 40);
        end
    endtask

    task automatic test_pc_wrap();
        do_reset();
        for (int i = 0; i < 16; i++) rom2[i] = 8'hE0;
        bus2.start = 1'b1;
        step();
        bus2.start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            tests++;
            if (bus2.instr_addr !== 4'(k)) begin
                fails++;
                $display("FAIL pc_wrap_addr k=%0d got %0d exp %0d", k, bus2.instr_addr, k);
            end
            step();
            step();
            step();
        end
        tests++;
        if (bus2.instr_addr !== 4'd0 || bus2.retired !== 8'd16) begin
            fails++;
            $display("FAIL pc_wrap_end got addr=%0d ret=%0d exp 0 16", bus2.instr_addr, bus2.retired);
        end
    endtask

    initial begin
        bus1.start = 1'b0;
        bus2.start = 1'b0;
        init_tables();
        test_reset();
        test_add();
        test_halt();
        test_jmp();
        test_illegal();
        test_reset_in_exec();
        test_random();
        test_pc_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
